// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider (signed/unsigned) with zero-divide and annul handling
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     rr, diff;
    logic               ge, sa, sb;

    // a_q shifts the dividend out MSB-first while quotient bits shift in from the bottom
    assign rr   = {r_q, a_q[WIDTH-1]};
    assign diff = rr - {1'b0, b_q};
    assign ge   = ~diff[WIDTH];
    assign sa   = signed_div_i & opdata1_i[WIDTH-1];
    assign sb   = signed_div_i & opdata2_i[WIDTH-1];

    // next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    a_d     = sa ? -opdata1_i : opdata1_i;
                    b_d     = sb ? -opdata2_i : opdata2_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    neg_q_d = sa ^ sb;
                    neg_r_d = sa;
                    busy_d  = 1'b1;
                    state_d = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                busy_d   = 1'b0;
                result_d = '0;
                ready_d  = !annul_i;
                state_d  = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    busy_d   = 1'b0;
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    result_d = {neg_r_q ? -r_q : r_q, neg_q_q ? -a_q : a_q};
                    state_d  = END;
                end else begin
                    a_d   = {a_q[WIDTH-2:0], ge};
                    r_d   = ge ? diff[WIDTH-1:0] : rr[WIDTH-1:0];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            END: begin
                if (!start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // state and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous and active-high.
REQ-004 SHALL have port signed_div_i, input, 1: 1 = signed (two's complement) divide, 0 = unsigned.
REQ-005 SHALL have port opdata1_i, input, WIDTH: dividend.
REQ-006 SHALL have port opdata2_i, input, WIDTH: divisor.
REQ-007 SHALL have port start_i, input, 1: divide request, level-held by requester until the result is consumed.
REQ-008 SHALL have port annul_i, input, 1: abort the current or pending divide.
REQ-009 SHALL have port result_o, output, 2*WIDTH: {remainder[2*WIDTH-1:WIDTH], quotient[WIDTH-1:0]}.
REQ-010 SHALL have port ready_o, output, 1: result_o valid.
REQ-011 SHALL have port busy_o, output, 1: high in states BYZERO and ON.

Function
REQ-012 SHALL implement states FREE, BYZERO, ON and END; all outputs SHALL be registered.
REQ-013 In FREE with start_i=1 and annul_i=0, SHALL capture signed_div_i and both operands on that edge (edge E0); later operand changes SHALL be ignored.
REQ-014 At E0, if opdata2_i==0, SHALL go to BYZERO; otherwise SHALL go to ON with step counter 0.
REQ-015 At E0, when signed_div_i=1, SHALL store operand magnitudes and record the two operand signs.
REQ-016 BYZERO SHALL go to END on the next edge with result_o = 0.
REQ-017 In ON, SHALL perform one restoring shift-subtract step per edge, producing one quotient bit MSB-first, for WIDTH steps.
REQ-018 ON SHALL go to END on the edge after step WIDTH completes.
REQ-019 On the ON-to-END edge, SHALL latch result_o after sign fix-up.
REQ-020 Signed sign fix-up: quotient SHALL be negated iff the operand signs differ; remainder SHALL be negated iff the dividend is negative.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH: signed most-negative / -1 SHALL give quotient = most-negative and remainder = 0.
REQ-022 Latency SHALL be exactly WIDTH+2 rising edges from E0 to ready_o=1 for nonzero divisors, and exactly 2 edges for a zero divisor.
REQ-023 In END, ready_o SHALL be 1 and result_o SHALL be held stable for as long as start_i=1.
REQ-024 In END, when start_i=0, SHALL return to FREE on the next edge with ready_o=0 and result_o=0.
REQ-025 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge with ready_o=0, result_o=0 and busy_o=0.
REQ-026 annul_i=1 in FREE SHALL block acceptance of start_i.
REQ-027 annul_i SHALL have no effect in END.
REQ-028 Deasserting start_i during ON or BYZERO SHALL NOT abort the operation; only annul_i aborts.
REQ-029 ready_o and busy_o SHALL never be high in the same cycle.
REQ-030 A new request SHALL be accepted no earlier than the first cycle in FREE after END or annul; there is no back-to-back acceptance from END.

Reset
REQ-031 While rst=1, state SHALL be FREE and result_o=0, ready_o=0, busy_o=0, step counter=0 and internal operand registers=0, regardless of clk.
REQ-032 Assertion of rst during any state SHALL clear all outputs immediately, without waiting for a clock edge.
REQ-033 After rst deasserts, the first rising edge SHALL evaluate FREE normally, so a start_i held through reset SHALL be accepted on that edge.

Verification (WIDTH=32 unless stated)
REQ-034 Unsigned 100/7 -> quotient 14 and remainder 2; ready_o rises exactly 34 edges after E0; result held while start_i=1; FREE one edge after start_i drops.
REQ-035 Signed -100/7 -> quotient 0xFFFFFFF2 and remainder 0xFFFFFFFE; signed 100/-7 -> quotient 0xFFFFFFF2 and remainder 2.
REQ-036 Divisor 0 (dividend 5) -> busy_o for 1 cycle, then ready_o=1 with result_o=0, 2 edges after E0.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-038 annul_i pulsed 10 edges after E0 -> FREE next edge with all outputs 0; a new 9/3 request then gives quotient 3, remainder 0.
REQ-039 rst asserted between clock edges mid-ON -> outputs 0 within the same cycle; repeat the REQ-034 and REQ-035 cases with WIDTH=8 (latency 10 edges).
